mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM pipeline stage of the LC-3b pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Sequences data-memory accesses (LDR/STR/LDB/STB/LDI/STI/TRAP) over the dmem request/response handshake.
- Holds the pipeline stalled until each access completes.
- Presents one registered result word to MEM/WB for one cycle per completed access.

Parameters:
- WIDTH, 16, data/address width.
- TIMEOUT, 255, max cycles waiting for dmem_resp on one access before error; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_mem_valid  in  1  EX/MEM holds a live, non-squashed instruction (control word nonzero).
- ex_mem_opcode  in  4  LC-3b opcode.
- ex_mem_addr  in  WIDTH  effective address (ALU result).
- ex_mem_store_data  in  WIDTH  store source register value.
- ex_mem_trap_vec  in  WIDTH  trap vector table address.
- dmem_rdata  in  WIDTH  read data.
- dmem_resp  in  1  access complete, one-cycle pulse.
- dmem_read  out  1  read request, held until resp.
- dmem_write  out  1  write request, held until resp.
- dmem_address  out  WIDTH  access address.
- dmem_wdata  out  WIDTH  write data.
- dmem_byte_enable  out  2  byte lanes for writes.
- mem_stall  out  1  freeze IF..EX/MEM registers.
- mem_result  out  WIDTH  load/trap data to MEM/WB.
- mem_result_valid  out  1  mem_result valid this cycle.
- mem_error  out  1  sticky timeout flag.

Behaviour:
- Memory ops: LDR 0110, STR 0111, LDB 0010, STB 0011, LDI 1010, STI 1011, TRAP 1111. All other opcodes, and any opcode with ex_mem_valid=0, are non-memory: no stall, no dmem activity.
- Reset values:
  - State IDLE.
  - dmem_read, dmem_write, mem_stall, mem_result_valid, mem_error all 0.
  - mem_result, dmem_address, dmem_wdata, dmem_byte_enable all 0.
  - Pointer register 0; wait counter 0.
- States: IDLE, IND, ACCESS, DONE.
  - IDLE + memory op: LDI/STI go to IND; all others go to ACCESS. Otherwise stay in IDLE.
  - IND: dmem_read=1, address = ex_mem_addr with bit0 cleared. On dmem_resp, latch dmem_rdata into the pointer and go to ACCESS.
  - ACCESS: address source by opcode:
    - TRAP: ex_mem_trap_vec.
    - LDI/STI: pointer.
    - All others: ex_mem_addr.
  - ACCESS request type: read for LDR/LDB/LDI/TRAP; write for STR/STB/STI. On dmem_resp, go to DONE.
  - DONE: exactly one cycle, then IDLE.
- Word accesses: address bit0 forced to 0; byte_enable=11.
- Byte accesses (LDB/STB): full address driven.
  - STB: wdata = {store[7:0], store[7:0]}; byte_enable = addr[0] ? 10 : 01.
  - LDB: result = sign-extend of rdata[15:8] if addr[0], else rdata[7:0].
- Result register: loaded on the ACCESS dmem_resp for reads. mem_result_valid=1 only during DONE, and only for reads. Stores leave mem_result unchanged.
- mem_stall is combinational: 1 when a memory op is present and state≠DONE. In DONE it is 0, so EX/MEM loads the next instruction at the end of DONE. IDLE never re-launches the completed op.
- Request signals are registered outputs of the state. They deassert the cycle after resp; no request is issued in DONE.
- Total stall cycles per op:
  - Single access: (1 + memory latency).
  - LDI/STI: both latencies + 1.
- Timeout (TIMEOUT≠0):
  - The counter clears on each new request and increments each cycle the request is held without resp.
  - At count==TIMEOUT: set mem_error (sticky until reset), drop the request, go to DONE with mem_result_valid=0. The pipeline is released.
- dmem_resp outside IND/ACCESS is ignored.
- Async reset mid-access: requests drop immediately (not at the next edge); state returns to IDLE; the pointer is cleared.

Decomposition:
- Shared package lc3b_types gets:
  - lc3b_opcode enum with the values above.
  - lc3b_mem_state enum {IDLE, IND, ACCESS, DONE}.
  - Helper functions is_mem_op(opcode), is_store(opcode).
- One sub-module: mem_byte_align. Combinational; produces STB lanes/wdata and the LDB sign-extension from addr[0].

Test Plan:
- LDR, addr 0x3001, mem[0x3000]=0xBEEF, resp after 3 cycles -> dmem_address 0x3000, read held 3 cycles, stall for 4 cycles, DONE shows mem_result 0xBEEF with valid=1.
- STB, addr 0x4001, store 0x12A5, resp after 1 cycle -> byte_enable 10, wdata 0xA5A5, write 1 cycle, no mem_result_valid.
- LDB, addr 0x4001, rdata 0x80FF -> mem_result 0xFF80. Same with addr 0x4000 -> 0xFFFF.
- LDI, addr 0x5000, mem[0x5000]=0x6002, mem[0x6002]=0x1234 -> two reads (0x5000, then 0x6002), mem_result 0x1234, stall covers both.
- TRAP, trap_vec 0x0046, mem=0x0200 -> read at 0x0046, mem_result 0x0200. Also: opcode ADD with valid=1 -> no request, stall 0.
- TIMEOUT=4, no resp -> request held 4 cycles, then mem_error=1, stall released. Separately, reset_n low mid-read -> dmem_read 0 immediately, state IDLE.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types: opcodes, MEM-stage states and opcode classification helpers.
package lc3b_types;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE,
    IND,
    ACCESS,
    DONE
  } lc3b_mem_state;

  // True for every opcode that touches data memory.
  function automatic logic is_mem_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI, OP_TRAP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the opcodes whose final access is a write.
  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
  endfunction

  // Indirect ops fetch a pointer before the real access.
  function automatic logic is_indirect(input logic [3:0] op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  // Byte-sized accesses keep the full address.
  function automatic logic is_byte_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB);
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering: STB write lanes/data and LDB sign-extended load data.
module mem_byte_align #(
  parameter int WIDTH = 16
) (
  input  logic             addr_lsb,
  input  logic [7:0]       store_byte,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] stb_wdata,
  output logic [1:0]       stb_byte_enable,
  output logic [WIDTH-1:0] ldb_data
);

  logic [7:0] load_byte;

  // The store byte is replicated on every lane; byte_enable picks the live one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH / 8; gi++) begin : g_lane
      assign stb_wdata[gi*8 +: 8] = store_byte;
    end
  endgenerate

  // Odd address writes the high lane, even address the low lane.
  assign stb_byte_enable = {addr_lsb, ~addr_lsb};

  // Pick the addressed byte and sign-extend it to the full word.
  assign load_byte = addr_lsb ? rdata[15:8] : rdata[7:0];
  assign ldb_data  = {{(WIDTH-8){load_byte[7]}}, load_byte};

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: sequences data-memory accesses, stalls the pipe until done,
// and hands one registered result word to MEM/WB per completed load.
module mem_stage
  import lc3b_types::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ex_mem_valid,
  input  logic [3:0]       ex_mem_opcode,
  input  logic [WIDTH-1:0] ex_mem_addr,
  input  logic [WIDTH-1:0] ex_mem_store_data,
  input  logic [WIDTH-1:0] ex_mem_trap_vec,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_address,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  output logic             mem_stall,
  output logic [WIDTH-1:0] mem_result,
  output logic             mem_result_valid,
  output logic             mem_error
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Timeout fires on the TIMEOUT-th held cycle without a response.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lc3b_mem_state    state_reg, state_next;
  logic [WIDTH-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             read_reg, read_next;
  logic             write_reg, write_next;
  logic [WIDTH-1:0] addr_reg, addr_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic [1:0]       be_reg, be_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             valid_reg, valid_next;
  logic             error_reg, error_next;

  logic             mem_op, op_store, op_ind, op_byte, op_trap;
  logic             timeout_hit;
  logic [WIDTH-1:0] ptr_src;
  logic [WIDTH-1:0] acc_addr, acc_wdata;
  logic [1:0]       acc_be;
  logic [WIDTH-1:0] stb_wdata, ldb_data;
  logic [1:0]       stb_be;

  function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] a);
    return a & ~{{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign mem_op   = ex_mem_valid && is_mem_op(ex_mem_opcode);
  assign op_store = is_store(ex_mem_opcode);
  assign op_ind   = is_indirect(ex_mem_opcode);
  assign op_byte  = is_byte_op(ex_mem_opcode);
  assign op_trap  = (ex_mem_opcode == OP_TRAP);

  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  // When leaving IND the pointer is being captured this very cycle.
  assign ptr_src = (state_reg == IND) ? dmem_rdata : ptr_reg;

  mem_byte_align #(.WIDTH(WIDTH)) u_align (
    .addr_lsb        (ex_mem_addr[0]),
    .store_byte      (ex_mem_store_data[7:0]),
    .rdata           (dmem_rdata),
    .stb_wdata       (stb_wdata),
    .stb_byte_enable (stb_be),
    .ldb_data        (ldb_data)
  );

  // Address, lanes and data for the final (non-pointer) access.
  always_comb begin
    acc_addr  = word_addr(ex_mem_addr);
    acc_be    = 2'b11;
    acc_wdata = ex_mem_store_data;
    if (op_trap) begin
      acc_addr = word_addr(ex_mem_trap_vec);
    end else if (op_ind) begin
      acc_addr = word_addr(ptr_src);
    end else if (op_byte) begin
      acc_addr = ex_mem_addr;
    end
    if (op_byte && op_store) begin
      acc_be    = stb_be;
      acc_wdata = stb_wdata;
    end
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    cnt_next    = cnt_reg;
    read_next   = read_reg;
    write_next  = write_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    be_next     = be_reg;
    result_next = result_reg;
    valid_next  = 1'b0;
    error_next  = error_reg;

    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          cnt_next = '0;
          if (op_ind) begin
            state_next = IND;
            read_next  = 1'b1;
            write_next = 1'b0;
            addr_next  = word_addr(ex_mem_addr);
            be_next    = 2'b11;
          end else begin
            state_next = ACCESS;
            read_next  = ~op_store;
            write_next = op_store;
            addr_next  = acc_addr;
            be_next    = acc_be;
            wdata_next = acc_wdata;
          end
        end
      end

      IND: begin
        if (dmem_resp) begin
          state_next = ACCESS;
          ptr_next   = dmem_rdata;
          cnt_next   = '0;
          read_next  = ~op_store;
          write_next = op_store;
          addr_next  = acc_addr;
          be_next    = acc_be;
          wdata_next = acc_wdata;
        end else if (timeout_hit) begin
          state_next = DONE;
          read_next  = 1'b0;
          write_next = 1'b0;
          error_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ACCESS: begin
        if (dmem_resp) begin
          state_next = DONE;
          read_next  = 1'b0;
          write_next = 1'b0;
          if (!op_store) begin
            result_next = op_byte ? ldb_data : dmem_rdata;
            valid_next  = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = DONE;
          read_next  = 1'b0;
          write_next = 1'b0;
          error_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops requests without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      cnt_reg    <= '0;
      read_reg   <= 1'b0;
      write_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      be_reg     <= 2'b00;
      result_reg <= '0;
      valid_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      read_reg   <= read_next;
      write_reg  <= write_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      be_reg     <= be_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
      error_reg  <= error_next;
    end
  end

  // DONE releases the stall so EX/MEM advances at the end of that cycle.
  assign mem_stall        = mem_op && (state_reg != DONE);
  assign dmem_read        = read_reg;
  assign dmem_write       = write_reg;
  assign dmem_address     = addr_reg;
  assign dmem_wdata       = wdata_reg;
  assign dmem_byte_enable = be_reg;
  assign mem_result       = result_reg;
  assign mem_result_valid = valid_reg;
  assign mem_error        = error_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a cycle-stepped memory responder per operation.
module tb_mem_stage;
  import lc3b_types::*;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ex_mem_valid;
  logic [3:0]       ex_mem_opcode;
  logic [WIDTH-1:0] ex_mem_addr;
  logic [WIDTH-1:0] ex_mem_store_data;
  logic [WIDTH-1:0] ex_mem_trap_vec;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_resp;
  logic             dmem_read;
  logic             dmem_write;
  logic [WIDTH-1:0] dmem_address;
  logic [WIDTH-1:0] dmem_wdata;
  logic [1:0]       dmem_byte_enable;
  logic             mem_stall;
  logic [WIDTH-1:0] mem_result;
  logic             mem_result_valid;
  logic             mem_error;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_opcode     (ex_mem_opcode),
    .ex_mem_addr       (ex_mem_addr),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_trap_vec   (ex_mem_trap_vec),
    .dmem_rdata        (dmem_rdata),
    .dmem_resp         (dmem_resp),
    .dmem_read         (dmem_read),
    .dmem_write        (dmem_write),
    .dmem_address      (dmem_address),
    .dmem_wdata        (dmem_wdata),
    .dmem_byte_enable  (dmem_byte_enable),
    .mem_stall         (mem_stall),
    .mem_result        (mem_result),
    .mem_result_valid  (mem_result_valid),
    .mem_error         (mem_error)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [15:0] mem_model [logic [15:0]];

  // Observations of the most recent operation.
  int          stall_cycles, rd_cycles, wr_cycles, valid_cycles, n_req;
  logic [15:0] req_addr [4];
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic [15:0] last_result;
  bit          op_finished;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one instruction, answer each request after lat1 (then lat2) held
  // cycles (0 = never answer), and record what the stage did.
  task automatic run_op(input string tag, input logic [3:0] op, input logic vld,
                        input logic [15:0] addr, input logic [15:0] store,
                        input logic [15:0] tvec, input int lat1, input int lat2);
    int  held;
    int  lat_cur;
    bit  seen_stall;
    stall_cycles = 0; rd_cycles = 0; wr_cycles = 0; valid_cycles = 0; n_req = 0;
    for (int i = 0; i < 4; i++) req_addr[i] = 16'h0;
    req_be = 2'b00; req_wdata = 16'h0; last_result = 16'h0;
    op_finished = 1'b0; seen_stall = 1'b0;
    held = 0; lat_cur = lat1;

    @(negedge clk);
    ex_mem_valid      = vld;
    ex_mem_opcode     = op;
    ex_mem_addr       = addr;
    ex_mem_store_data = store;
    ex_mem_trap_vec   = tvec;
    dmem_resp         = 1'b0;

    for (int cyc = 0; cyc < 40 && !op_finished; cyc++) begin
      #1;
      dmem_resp = 1'b0;
      if (mem_stall) begin
        stall_cycles++;
        seen_stall = 1'b1;
      end
      if (dmem_read || dmem_write) begin
        held++;
        if (held == 1) begin
          if (n_req < 4) req_addr[n_req] = dmem_address;
          req_be    = dmem_byte_enable;
          req_wdata = dmem_wdata;
          n_req++;
        end
        if (dmem_read) rd_cycles++;
        else           wr_cycles++;
        if (lat_cur != 0 && held == lat_cur) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_model.exists(dmem_address) ? mem_model[dmem_address] : 16'h0;
          held       = 0;
          lat_cur    = lat2;
        end
      end
      if (mem_result_valid) begin
        valid_cycles++;
        last_result = mem_result;
      end
      if (!mem_stall && (seen_stall || cyc >= 2)) op_finished = 1'b1;
      else @(negedge clk);
    end

    // The pipeline moves on: EX/MEM now holds a bubble.
    ex_mem_valid = 1'b0;
    dmem_resp    = 1'b0;
    check_val({tag, "_finished"}, {31'd0, op_finished}, 32'd1);
    @(negedge clk);
    #1;
    check_val({tag, "_idle_req"}, {30'd0, dmem_read, dmem_write}, 32'd0);
    check_val({tag, "_idle_valid"}, {31'd0, mem_result_valid}, 32'd0);
    $display("op %s opc=%b addr=%h stall=%0d reqs=%0d rd=%0d wr=%0d a0=%h a1=%h be=%b wd=%h valid=%0d res=%h err=%b",
             tag, op, addr, stall_cycles, n_req, rd_cycles, wr_cycles, req_addr[0], req_addr[1],
             req_be, req_wdata, valid_cycles, last_result, mem_error);
  endtask

  initial begin
    reset_n           = 1'b0;
    ex_mem_valid      = 1'b0;
    ex_mem_opcode     = 4'h0;
    ex_mem_addr       = 16'h0;
    ex_mem_store_data = 16'h0;
    ex_mem_trap_vec   = 16'h0;
    dmem_rdata        = 16'h0;
    dmem_resp         = 1'b0;

    mem_model[16'h3000] = 16'hBEEF;
    mem_model[16'h4001] = 16'h80FF;
    mem_model[16'h4000] = 16'h80FF;
    mem_model[16'h5000] = 16'h6002;
    mem_model[16'h6002] = 16'h1234;
    mem_model[16'h0046] = 16'h0200;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_read",   {31'd0, dmem_read}, 32'd0);
    check_val("rst_write",  {31'd0, dmem_write}, 32'd0);
    check_val("rst_stall",  {31'd0, mem_stall}, 32'd0);
    check_val("rst_valid",  {31'd0, mem_result_valid}, 32'd0);
    check_val("rst_error",  {31'd0, mem_error}, 32'd0);
    check_val("rst_result", {16'd0, mem_result}, 32'h0);
    check_val("rst_addr",   {16'd0, dmem_address}, 32'h0);
    check_val("rst_wdata",  {16'd0, dmem_wdata}, 32'h0);
    check_val("rst_be",     {30'd0, dmem_byte_enable}, 32'h0);
    reset_n = 1'b1;

    // LDR: odd address is word-aligned, 3-cycle latency
    run_op("ldr", OP_LDR, 1'b1, 16'h3001, 16'h0, 16'h0, 3, 0);
    check_val("ldr_addr",   {16'd0, req_addr[0]}, 32'h3000);
    check_val("ldr_rd",     rd_cycles, 3);
    check_val("ldr_wr",     wr_cycles, 0);
    check_val("ldr_stall",  stall_cycles, 4);
    check_val("ldr_valid",  valid_cycles, 1);
    check_val("ldr_result", {16'd0, last_result}, 32'hBEEF);

    // STB to the high byte
    run_op("stb", OP_STB, 1'b1, 16'h4001, 16'h12A5, 16'h0, 1, 0);
    check_val("stb_addr",  {16'd0, req_addr[0]}, 32'h4001);
    check_val("stb_be",    {30'd0, req_be}, 32'h2);
    check_val("stb_wdata", {16'd0, req_wdata}, 32'hA5A5);
    check_val("stb_wr",    wr_cycles, 1);
    check_val("stb_rd",    rd_cycles, 0);
    check_val("stb_stall", stall_cycles, 2);
    check_val("stb_valid", valid_cycles, 0);

    // LDB high and low bytes, sign-extended
    run_op("ldb_hi", OP_LDB, 1'b1, 16'h4001, 16'h0, 16'h0, 2, 0);
    check_val("ldb_hi_addr",   {16'd0, req_addr[0]}, 32'h4001);
    check_val("ldb_hi_result", {16'd0, last_result}, 32'hFF80);
    run_op("ldb_lo", OP_LDB, 1'b1, 16'h4000, 16'h0, 16'h0, 2, 0);
    check_val("ldb_lo_addr",   {16'd0, req_addr[0]}, 32'h4000);
    check_val("ldb_lo_result", {16'd0, last_result}, 32'hFFFF);

    // LDI: pointer fetch then data fetch
    run_op("ldi", OP_LDI, 1'b1, 16'h5000, 16'h0, 16'h0, 2, 1);
    check_val("ldi_nreq",   n_req, 2);
    check_val("ldi_addr0",  {16'd0, req_addr[0]}, 32'h5000);
    check_val("ldi_addr1",  {16'd0, req_addr[1]}, 32'h6002);
    check_val("ldi_rd",     rd_cycles, 3);
    check_val("ldi_stall",  stall_cycles, 4);
    check_val("ldi_result", {16'd0, last_result}, 32'h1234);

    // TRAP reads the vector table
    run_op("trap", OP_TRAP, 1'b1, 16'h1111, 16'h0, 16'h0046, 1, 0);
    check_val("trap_addr",   {16'd0, req_addr[0]}, 32'h0046);
    check_val("trap_result", {16'd0, last_result}, 32'h0200);
    check_val("trap_stall",  stall_cycles, 2);

    // STR word store leaves the result register alone
    run_op("str", OP_STR, 1'b1, 16'h7003, 16'h5A5A, 16'h0, 2, 0);
    check_val("str_addr",   {16'd0, req_addr[0]}, 32'h7002);
    check_val("str_be",     {30'd0, req_be}, 32'h3);
    check_val("str_wdata",  {16'd0, req_wdata}, 32'h5A5A);
    check_val("str_stall",  stall_cycles, 3);
    check_val("str_keep",   {16'd0, mem_result}, 32'h0200);

    // Non-memory and squashed instructions
    run_op("add", OP_ADD, 1'b1, 16'h3000, 16'h0, 16'h0, 1, 0);
    check_val("add_stall", stall_cycles, 0);
    check_val("add_nreq",  n_req, 0);
    run_op("ldr_squash", OP_LDR, 1'b0, 16'h3000, 16'h0, 16'h0, 1, 0);
    check_val("squash_stall", stall_cycles, 0);
    check_val("squash_nreq",  n_req, 0);

    // Timeout: memory never answers
    run_op("tmo", OP_LDR, 1'b1, 16'h3000, 16'h0, 16'h0, 0, 0);
    check_val("tmo_rd",    rd_cycles, 4);
    check_val("tmo_stall", stall_cycles, 5);
    check_val("tmo_valid", valid_cycles, 0);
    check_val("tmo_error", {31'd0, mem_error}, 32'd1);

    // Error stays set across a good access
    run_op("trap2", OP_TRAP, 1'b1, 16'h0, 16'h0, 16'h0046, 1, 0);
    check_val("sticky_error", {31'd0, mem_error}, 32'd1);

    // Asynchronous reset in the middle of a read
    @(negedge clk);
    ex_mem_valid  = 1'b1;
    ex_mem_opcode = OP_LDR;
    ex_mem_addr   = 16'h3000;
    @(negedge clk);
    #1;
    check_val("arst_pre_read", {31'd0, dmem_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst_read",   {31'd0, dmem_read}, 32'd0);
    check_val("arst_addr",   {16'd0, dmem_address}, 32'h0);
    check_val("arst_error",  {31'd0, mem_error}, 32'd0);
    check_val("arst_result", {16'd0, mem_result}, 32'h0);
    $display("op arst read=%b addr=%h err=%b", dmem_read, dmem_address, mem_error);
    ex_mem_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Fresh LDR after reset starts from IDLE
    run_op("ldr_post", OP_LDR, 1'b1, 16'h3000, 16'h0, 16'h0, 1, 0);
    check_val("post_stall",  stall_cycles, 2);
    check_val("post_result", {16'd0, last_result}, 32'hBEEF);
    check_val("post_error",  {31'd0, mem_error}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
